// File: rtl/mc_ctrl.sv
// Purpose: multi-cycle MIPS main controller; sequences the shared ALU/memory/regfile datapath per opcode.
// Latency: R/ORI/ADDIU 4, LW 5, SW 4, BEQ 3, J 3 cycles; each memory wait cycle adds one.
// Backpressure: FETCH/MEM_RD/MEM_WR hold on mem_ready=0; a saturating wait counter aborts to FETCH with mem_err.
module mc_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int WAIT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWr,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWr,
  output logic       ExtOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] cnt;
  logic              rdy;
  logic              in_wait;
  logic              timeout;

  // Without the handshake, memory is assumed to complete every access in one cycle.
  assign rdy     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign in_wait = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  assign timeout = (MEM_HANDSHAKE != 0) && in_wait && !mem_ready && (cnt == CNT_MAX);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Wait counter: counts stalled cycles in a memory state; any exit (completion or timeout) clears it.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((MEM_HANDSHAKE != 0) && in_wait && !mem_ready && (cnt != CNT_MAX))
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // Next-state and control decode; everything stays 0 while rst is high.
  always_comb begin
    PCWr = 1'b0; PCWrCond = 1'b0; IorD = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
    IRWr = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0; RegWr = 1'b0; ExtOp = 1'b0;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; PCSrc = 2'b00; ALUOp = 3'b000;
    instr_done = 1'b0; illegal_op = 1'b0; mem_err = 1'b0;
    state = 4'd0;
    nxt   = cur;
    if (!rst) begin
      state = cur;
      case (cur)
        S_FETCH: begin
          MemRd   = !timeout;
          ALUSrcB = 2'b01;
          IRWr    = rdy;
          PCWr    = rdy;
          mem_err = timeout;
          if (rdy)          nxt = S_DECODE;
          else if (timeout) nxt = S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ExtOp   = 1'b1;
          case (op)
            OP_R:             nxt = S_EXEC_R;
            OP_ORI, OP_ADDIU: nxt = S_EXEC_I;
            OP_LW, OP_SW:     nxt = S_MEM_ADDR;
            OP_BEQ:           nxt = S_BRANCH;
            OP_J:             nxt = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              nxt        = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
          nxt     = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          MemRd   = !timeout;
          IorD    = 1'b1;
          mem_err = timeout;
          if (rdy)          nxt = S_MEM_WB;
          else if (timeout) nxt = S_FETCH;
        end
        S_MEM_WB: begin
          MemtoReg   = 1'b1;
          RegWr      = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEM_WR: begin
          MemWr      = !timeout;
          IorD       = 1'b1;
          instr_done = rdy;
          mem_err    = timeout;
          if (rdy || timeout) nxt = S_FETCH;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b111;
          nxt     = S_WB_R;
        end
        S_WB_R: begin
          RegDst     = 1'b1;
          RegWr      = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (op == OP_ORI) begin
            ExtOp = 1'b0;
            ALUOp = 3'b011;
          end else begin
            ExtOp = 1'b1;
            ALUOp = 3'b000;
          end
          nxt = S_WB_I;
        end
        S_WB_I: begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 3'b001;
          PCSrc      = 2'b01;
          PCWrCond   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          PCWr       = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule
